// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, instruction window size, fetch FSM
// states, and the helper that places one memory beat into the instruction window.
package y86_pkg;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_ADR = 4'd2;
  localparam logic [3:0] STAT_INS = 4'd3;
  localparam logic [3:0] STAT_HLT = 4'd4;

  localparam int INSTR_BYTES = 10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    PRESENT,
    WAIT_PC,
    HALTED
  } fetch_state_e;

  // Byte k of the beat lands at window byte first+k. Window bytes whose keep
  // bit is clear are zeroed. Beat bytes beyond the window are dropped.
  function automatic logic [0:8*INSTR_BYTES-1] place_beat(
    input logic [0:8*INSTR_BYTES-1] cur,
    input logic [8*INSTR_BYTES-1:0] data,
    input int                       first,
    input int                       nbytes,
    input logic [INSTR_BYTES-1:0]   keep
  );
    logic [0:8*INSTR_BYTES-1] res;
    logic [6:0]               dst;
    logic [6:0]               src;
    res = cur;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      if (i >= first && i < first + nbytes) begin
        dst = 7'(8 * i);
        src = 7'(8 * (i - first));
        res[dst +: 8] = keep[4'(i)] ? data[src +: 8] : 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/instr_prefetch.sv
// Instruction prefetcher for the SEQ core: owns the PC, assembles the 10-byte
// window at PC from a narrow memory, hands it over, and waits for the next PC.
module instr_prefetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          FETCH_BYTES = 2,
  parameter int          MEM_BYTES   = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_rd_en,
  output logic [63:0]                mem_addr,
  input  logic [8*FETCH_BYTES-1:0]   mem_rdata,
  input  logic                       mem_rvalid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                pc,
  output logic [0:79]                instr,
  output logic                       imem_error,
  input  logic                       pc_load,
  input  logic [63:0]                new_pc,
  input  logic [3:0]                 stat_in,
  output logic                       halted,
  output logic [31:0]                instr_count,
  output fetch_state_e               fsm_state
);

  localparam int          BEATS     = (INSTR_BYTES + FETCH_BYTES - 1) / FETCH_BYTES;
  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [3:0]        beat;
  logic [64:0]       beat_addr;
  logic              beat_oor;
  logic              pc_oor;
  logic              last_beat;
  int                first_byte;
  logic [9:0]        byte_ok;

  // Addresses are computed 65 bits wide so a wrap past 2^64 reads as out of range.
  always_comb begin
    beat_addr  = {1'b0, pc} + 65'(beat) * 65'(FETCH_BYTES);
    beat_oor   = beat_addr >= MEM_LIMIT;
    pc_oor     = {1'b0, pc} >= MEM_LIMIT;
    last_beat  = beat == 4'(BEATS - 1);
    first_byte = int'(beat) * FETCH_BYTES;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      byte_ok[4'(i)] = ({1'b0, pc} + 65'(i)) < MEM_LIMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = FETCH_REQ;
      FETCH_REQ: begin
        if (beat == 4'd0 && pc_oor) state_nxt = PRESENT;
        else if (beat_oor)          state_nxt = last_beat ? PRESENT : FETCH_REQ;
        else                        state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: if (mem_rvalid) state_nxt = last_beat ? PRESENT : FETCH_REQ;
      PRESENT:    if (out_ready)  state_nxt = WAIT_PC;
      WAIT_PC:    if (pc_load)    state_nxt = (stat_in == STAT_AOK) ? FETCH_REQ : HALTED;
      HALTED:     state_nxt = HALTED;
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake: a transfer happens on any rising edge where out_valid && out_ready;
  // out_valid never drops and pc/instr/imem_error never change until that transfer.
  always_comb begin
    mem_rd_en = (state == FETCH_REQ) && !beat_oor;
    mem_addr  = mem_rd_en ? beat_addr[63:0] : 64'h0;
    out_valid = state == PRESENT;
    halted    = state == HALTED;
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      imem_error  <= 1'b0;
      beat        <= 4'd0;
      instr_count <= 32'd0;
    end else begin
      case (state)
        IDLE: beat <= 4'd0;
        FETCH_REQ: begin
          if (beat == 4'd0 && pc_oor) begin
            instr      <= '0;
            imem_error <= 1'b1;
          end else if (beat_oor) begin
            instr <= place_beat(instr, '0, first_byte, FETCH_BYTES, '0);
            beat  <= last_beat ? 4'd0 : beat + 4'd1;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            instr <= place_beat(instr, 80'(mem_rdata), first_byte, FETCH_BYTES, byte_ok);
            beat  <= last_beat ? 4'd0 : beat + 4'd1;
          end
        end
        PRESENT: if (out_ready) instr_count <= instr_count + 32'd1;
        WAIT_PC: begin
          if (pc_load) begin
            pc         <= new_pc;
            imem_error <= 1'b0;
            beat       <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: byte-array memory with programmable wait
// states, request log compared against an expected address queue.
module tb_instr_prefetch;
  import y86_pkg::*;

  logic         clk;
  logic         reset;
  logic         mem_rd_en;
  logic [63:0]  mem_addr;
  logic [15:0]  mem_rdata;
  logic         mem_rvalid;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  pc;
  logic [0:79]  instr;
  logic         imem_error;
  logic         pc_load;
  logic [63:0]  new_pc;
  logic [3:0]   stat_in;
  logic         halted;
  logic [31:0]  instr_count;
  fetch_state_e fsm_state;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:1023];
  int          mem_wait;
  logic        pend;
  int          cnt;
  logic [63:0] raddr;
  logic [63:0] req_q [$];
  logic [63:0] exp_q [$];

  instr_prefetch #(.RESET_PC(64'h0), .FETCH_BYTES(2), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid),
    .out_ready(out_ready), .pc(pc), .instr(instr), .imem_error(imem_error),
    .pc_load(pc_load), .new_pc(new_pc), .stat_in(stat_in), .halted(halted),
    .instr_count(instr_count), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    return (a < 64'd1024) ? mem[a[9:0]] : 8'hEE;
  endfunction

  // memory model: wait 0 answers in the cycle right after the request
  always @(posedge clk) begin
    if (reset) begin
      pend       <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_rd_en) begin
        if (mem_wait == 0) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= {rd_byte(mem_addr + 64'd1), rd_byte(mem_addr)};
        end else begin
          pend  <= 1'b1;
          cnt   <= mem_wait - 1;
          raddr <= mem_addr;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          pend       <= 1'b0;
          mem_rvalid <= 1'b1;
          mem_rdata  <= {rd_byte(raddr + 64'd1), rd_byte(raddr)};
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) if (mem_rd_en === 1'b1) req_q.push_back(mem_addr);

  // scoreboard
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reqs(input string tag);
    int n;
    check({tag, "_count"}, 128'(req_q.size()), 128'(exp_q.size()));
    n = (req_q.size() < exp_q.size()) ? req_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_addr%0d", tag, i), req_q[i], exp_q[i]);
    req_q.delete();
    exp_q.delete();
  endtask

  // drivers
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check(tag, out_valid, 1'b0);
  endtask

  task automatic load_pc(input logic [63:0] a, input logic [3:0] s);
    new_pc  = a;
    stat_in = s;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen_valid;
    reset = 1'b1; out_ready = 1'b0; pc_load = 1'b0; new_pc = '0; stat_in = '0;
    mem_wait = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h08;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    mem[1020] = 8'h60; mem[1021] = 8'h01; mem[1022] = 8'h10; mem[1023] = 8'h20;

    repeat (3) @(negedge clk);
    check("rst_pc", pc, 64'h0);
    check("rst_instr", instr, 80'h0);
    check("rst_imem_error", imem_error, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_count", instr_count, 32'd0);
    check("rst_state", fsm_state, IDLE);

    // nominal fetch at 0
    reset = 1'b0;
    @(negedge clk);
    check("nom_state_req", fsm_state, FETCH_REQ);
    wait_valid(cyc);
    check("nom_latency", cyc, 10);
    check("nom_pc", pc, 64'h0);
    check("nom_instr", instr, 80'h30F20800000000000000);
    check("nom_imem_error", imem_error, 1'b0);
    exp_q = '{64'd0, 64'd2, 64'd4, 64'd6, 64'd8};
    check_reqs("nom_req");

    // hold with out_ready low; pc_load in PRESENT must be ignored
    new_pc = 64'h55; stat_in = STAT_HLT; pc_load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pc_load = 1'b0;
      check($sformatf("hold_instr%0d", k), instr, 80'h30F20800000000000000);
      check($sformatf("hold_valid%0d", k), out_valid, 1'b1);
    end
    check("hold_pc", pc, 64'h0);
    check("hold_halted", halted, 1'b0);
    handshake("hs1_valid");
    check("hs1_count", instr_count, 32'd1);
    check("hs1_state", fsm_state, WAIT_PC);

    // next PC 0x0A
    load_pc(64'h0A, STAT_AOK);
    wait_valid(cyc);
    check("pc0a_latency", cyc, 10);
    check("pc0a_pc", pc, 64'h0A);
    check("pc0a_instr", instr, 80'hAFAEA9A8ABAAB5B4B7B6);
    exp_q = '{64'h0A, 64'h0C, 64'h0E, 64'h10, 64'h12};
    check_reqs("pc0a_req");
    handshake("hs2_valid");
    check("hs2_count", instr_count, 32'd2);

    // memory end, even pc
    load_pc(64'd1020, STAT_AOK);
    wait_valid(cyc);
    check("end_latency", cyc, 7);
    check("end_instr", instr, 80'h60011020000000000000);
    check("end_imem_error", imem_error, 1'b0);
    exp_q = '{64'd1020, 64'd1022};
    check_reqs("end_req");
    handshake("hs3_valid");

    // memory end, odd pc: second byte of the beat lies past the end
    load_pc(64'd1023, STAT_AOK);
    wait_valid(cyc);
    check("odd_latency", cyc, 6);
    check("odd_instr", instr, 80'h20000000000000000000);
    exp_q = '{64'd1023};
    check_reqs("odd_req");
    handshake("hs4_valid");

    // address error
    load_pc(64'h400, STAT_AOK);
    wait_valid(cyc);
    check("err_latency", cyc, 1);
    check("err_instr", instr, 80'h0);
    check("err_imem_error", imem_error, 1'b1);
    check_reqs("err_req");
    handshake("hs5_valid");
    check("hs5_count", instr_count, 32'd5);

    // halt
    load_pc(64'h20, STAT_HLT);
    check("hlt_halted", halted, 1'b1);
    check("hlt_pc", pc, 64'h20);
    check("hlt_imem_error", imem_error, 1'b0);
    seen_valid = 0;
    out_ready = 1'b1; new_pc = 64'h99; stat_in = STAT_AOK;
    for (int k = 0; k < 50; k++) begin
      pc_load = (k % 10 == 0);
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    pc_load = 1'b0; out_ready = 1'b0;
    check("hlt_no_valid", seen_valid, 0);
    check_reqs("hlt_req");
    check("hlt_pc_kept", pc, 64'h20);
    check("hlt_count_kept", instr_count, 32'd5);
    check("hlt_still", halted, 1'b1);

    // reset during FETCH_WAIT of beat 2 with 3 wait states
    mem_wait = 3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_q.delete();
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (mem_rd_en === 1'b1 && mem_addr === 64'd4) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("mid_state_wait", fsm_state, FETCH_WAIT);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pc", pc, 64'h0);
    check("mid_rst_instr", instr, 80'h0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_rd_en", mem_rd_en, 1'b0);
    check("mid_rst_halted", halted, 1'b0);
    check("mid_rst_count", instr_count, 32'd0);
    check("mid_rst_state", fsm_state, IDLE);
    req_q.delete();
    reset = 1'b0;
    @(negedge clk);
    wait_valid(cyc);
    check("ws_latency", cyc, 25);
    check("ws_instr", instr, 80'h30F20800000000000000);
    exp_q = '{64'd0, 64'd2, 64'd4, 64'd6, 64'd8};
    check_reqs("ws_req");
    handshake("hs6_valid");
    check("hs6_count", instr_count, 32'd1);

    // status outside 1..4 halts too
    load_pc(64'h40, 4'd0);
    check("bad_stat_halted", halted, 1'b1);
    check("bad_stat_pc", pc, 64'h40);
    repeat (5) @(negedge clk);
    check_reqs("bad_stat_req");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
